// File: rtl/mult_pkg.sv
// Shared constants for the sequential signed multiplier: widths, FSM encoding, iteration bound.
// Pure definitions; no timing or flow control of its own.
package mult_pkg;
  localparam int N_BITS = 32;
  localparam int CNT_W  = 6;
  localparam int PROD_W = 2 * N_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;

  // Signed overflow: the upper half plus the result sign bit must all match.
  function automatic logic isOverflow(input logic [PROD_W-1:0] p);
    return !((&p[PROD_W-1:N_BITS-1]) || !(|p[PROD_W-1:N_BITS-1]));
  endfunction
endpackage

// File: rtl/add_sub_64.sv
// 64-bit combinational adder/subtractor used by the multiplier accumulate step.
// Zero latency; no flow control, carry/borrow out is discarded.
module add_sub_64
  import mult_pkg::*;
(
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  input  logic              sub,
  output logic [PROD_W-1:0] y
);

  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/seq_mult_32bit.sv
// Signed 32x32 shift-and-add multiplier: result and one-cycle ready pulse 32 edges after start.
// No backpressure: a start pulse in any state restarts, an aborted operation never signals ready.
module seq_mult_32bit
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_MULT,
  input  logic [N_BITS-1:0] data_operandA,
  input  logic [N_BITS-1:0] data_operandB,
  output logic [N_BITS-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] mcand;
  logic [N_BITS-1:0] mplier;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] sum;
  logic              lastIter;

  assign lastIter = (cnt == LAST_ITER);

  // Bit 31 of the multiplier carries weight -2^31, so its partial product is subtracted.
  assign pp = (mcand & {PROD_W{mplier[cnt[4:0]]}}) << cnt;

  add_sub_64 uAcc (
    .a   (prod),
    .b   (pp),
    .sub (lastIter),
    .y   (sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      prod           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_MULT) begin
      mcand          <= {{N_BITS{data_operandA[N_BITS-1]}}, data_operandA};
      mplier         <= data_operandB;
      prod           <= '0;
      cnt            <= '0;
      state          <= RUN;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          prod <= sum;
          cnt  <= cnt + CNT_W'(1);
          if (lastIter) begin
            data_result    <= sum[N_BITS-1:0];
            data_exception <= isOverflow(sum);
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
